// File: rtl/rvv_backend_vrf_pkg.sv
// rtl/rvv_backend_vrf_pkg.sv - shared types and constants for the VRF storage array
package rvv_backend_vrf_pkg;

  localparam int DEF_VLEN     = 128;
  localparam int DEF_NUM_VREG = 32;
  localparam int VREG_IDX_W   = $clog2(DEF_NUM_VREG);

  typedef logic [DEF_VLEN-1:0] vreg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } vrf_dump_state_e;

endpackage

// File: rtl/rvv_backend_vrf_dump_fsm.sv
// rtl/rvv_backend_vrf_dump_fsm.sv - streams every vector register out over a valid/ready port
module rvv_backend_vrf_dump_fsm
  import rvv_backend_vrf_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int NUM_VREG = 32,
  parameter int IDX_W    = $clog2(NUM_VREG)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VREG-1:0][VLEN-1:0]  rd_plane,
  input  logic                           dump_start,
  input  logic                           dump_ready,
  output logic                           dump_busy,
  output logic                           dump_valid,
  output logic [IDX_W-1:0]               dump_idx,
  output logic [VLEN-1:0]                dump_data,
  output logic                           dump_last,
  output logic                           dump_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VREG - 1);

  vrf_dump_state_e  state;
  logic [IDX_W-1:0] next_idx;

  assign next_idx = dump_idx + 1'b1;

  // Each beat is captured from the storage flops when it is loaded, so a held
  // beat stays stable while later registers still reflect in-flight writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state      <= SEND;
            dump_busy  <= 1'b1;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= rd_plane[0];
            dump_last  <= 1'b0;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx  <= next_idx;
              dump_data <= rd_plane[next_idx];
              dump_last <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_busy <= 1'b0;
          dump_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_busy  <= 1'b0;
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rvv_backend_vrf_array.sv
// rtl/rvv_backend_vrf_array.sv - VRF storage with per-bit write mask, full read plane and dump port
module rvv_backend_vrf_array
  import rvv_backend_vrf_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int NUM_VREG = 32,
  parameter int IDX_W    = $clog2(NUM_VREG)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VREG-1:0][VLEN-1:0]  vrf_wr_wenb_full,
  input  logic [NUM_VREG-1:0][VLEN-1:0]  vrf_wr_data_full,
  output logic [NUM_VREG-1:0][VLEN-1:0]  vrf_rd_data_full,
  input  logic                           dump_start,
  output logic                           dump_busy,
  output logic                           dump_valid,
  input  logic                           dump_ready,
  output logic [IDX_W-1:0]               dump_idx,
  output logic [VLEN-1:0]                dump_data,
  output logic                           dump_last,
  output logic                           dump_done
);

  logic [NUM_VREG-1:0][VLEN-1:0] vreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vreg <= '0;
    end else begin
      vreg <= (vreg & ~vrf_wr_wenb_full) | (vrf_wr_data_full & vrf_wr_wenb_full);
    end
  end

  assign vrf_rd_data_full = vreg;

  rvv_backend_vrf_dump_fsm #(
    .VLEN     (VLEN),
    .NUM_VREG (NUM_VREG),
    .IDX_W    (IDX_W)
  ) u_dump_fsm (
    .clk        (clk),
    .rst        (rst),
    .rd_plane   (vreg),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .dump_done  (dump_done)
  );

endmodule
